// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate generator: format codes, major opcodes, XLEN check.
// No logic or state; imported by imm_gen_decode and imm_gen_pipe.
// Not applicable: no handshake at package level.
package imm_gen_pkg;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational decode of a 32-bit instruction word into format code and sign-extended immediate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipe owns all handshaking.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt
);

    logic [31:0] imm32;

    always_comb begin
        fmt   = FMT_ILL;
        imm32 = '0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_OP, OP_OP32: begin
                fmt   = FMT_R;
            end
            default: ;
        endcase
    end

    // Every 32-bit immediate already carries bit 31 as its sign; widen by sign extension.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator stage: decode + one output register, or a 2-entry skid buffer with IMM_GEN_SKID_EN.
// Latency: 1 cycle from input transfer to out_valid; sustained throughput 1 per cycle.
// Backpressure: in_ready = out_ready | ~out_valid (default) or registered skid-empty flag (IMM_GEN_SKID_EN).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (!xlen_legal(XLEN)) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam int PW = XLEN + 3 + TAG_W;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic [PW-1:0]   dec_dat;
    logic [PW-1:0]   out_dat;
    logic            push;
    logic            pop;

    imm_gen_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    assign dec_dat = {dec_imm, dec_fmt, in_tag};
    assign push    = in_valid & in_ready;
    assign pop     = out_valid & out_ready;

    assign {out_imm, out_fmt, out_tag} = out_dat;
    assign out_illegal = (out_fmt == FMT_ILL);

`ifdef IMM_GEN_SKID_EN
    logic          skid_empty;
    logic [PW-1:0] skid_dat;

    // in_ready comes straight from a flop; reset gating only, never out_ready.
    assign in_ready = skid_empty & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_dat    <= '0;
            skid_empty <= 1'b1;
            skid_dat   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_empty <= 1'b1;
        end else if (!skid_empty) begin
            if (pop) begin
                out_dat    <= skid_dat;
                skid_empty <= 1'b1;
            end
        end else if (push) begin
            if (!out_valid || pop) begin
                out_valid <= 1'b1;
                out_dat   <= dec_dat;
            end else begin
                skid_empty <= 1'b0;
                skid_dat   <= dec_dat;
            end
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready = ~reset & (out_ready | ~out_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_dat   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (push) begin
            out_valid <= 1'b1;
            out_dat   <= dec_dat;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed vectors with hand-computed immediates, stall, flush, reset.
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
`ifdef IMM_GEN_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [4:0]  tag;
    } exp_t;

    localparam int NV = 12;
    logic [31:0] vi [NV] = '{
        32'hFFF00093, 32'hFE112E23, 32'h800002B7, 32'h001000EF,
        32'h0000007F, 32'h00B50533, 32'hFE000EE3, 32'h00412083,
        32'h12345017, 32'hFFDFF0EF, 32'h00000073, 32'hFFFFFFFF
    };
    logic [63:0] vimm [NV] = '{
        64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h0000000000000800,
        64'h0000000000000000, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000004,
        64'h0000000012345000, 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000000, 64'h0000000000000000
    };
    logic [2:0] vfmt [NV] = '{
        3'd1, 3'd2, 3'd4, 3'd5,
        3'd7, 3'd0, 3'd3, 3'd1,
        3'd4, 3'd5, 3'd1, 3'd7
    };

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic        hold_chk = 1'b0;
    logic [72:0] held;
    logic        toggle_en = 1'b0;
    logic [7:0]  pat = 8'b1011_0110;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (toggle_en) begin
            #1;
            out_ready = pat[cyc % 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every output transfer and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (reset || flush) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk && out_valid) begin
                tests++;
                if ({out_imm, out_fmt, out_tag, out_illegal} !== held) begin
                    fails++;
                    $display("FAIL hold: got %h, want %h", {out_imm, out_fmt, out_tag, out_illegal}, held);
                end
            end
            hold_chk = out_valid && !out_ready;
            held     = {out_imm, out_fmt, out_tag, out_illegal};
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected output: tag %0d imm %h, want nothing", out_tag, out_imm);
                end else begin
                    e = sb.pop_front();
                    if ({out_imm, out_fmt, out_tag, out_illegal} !== {e.imm, e.fmt, e.tag, e.fmt == 3'd7}) begin
                        fails++;
                        $display("FAIL result tag %0d: got imm %h fmt %0d tag %0d ill %0b, want imm %h fmt %0d tag %0d",
                                 e.tag, out_imm, out_fmt, out_tag, out_illegal, e.imm, e.fmt, e.tag);
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [4:0] tag);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_instr = vi[k];
        in_tag   = tag;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            sb.push_back('{imm: vimm[k], fmt: vfmt[k], tag: tag});
        end else begin
            tests++;
            fails++;
            $display("FAIL send timeout: tag %0d never accepted, want accept", tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int c0;
        int acc;
        int idx;
        bit got;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_out_imm", out_imm, 64'd0);
        chk("post_rst_out_fmt", 64'(out_fmt), 64'd0);
        chk("post_rst_out_tag", 64'(out_tag), 64'd0);
        chk("post_rst_out_illegal", 64'(out_illegal), 64'd0);
        @(posedge clk);
        #1;

        // Single addi: result must be visible exactly one cycle after acceptance.
        send(0, 5'd1);
        @(negedge clk);
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // All vectors back to back: one accept per cycle.
        c0 = cyc;
        for (int k = 0; k < NV; k++) send(k, 5'(k));
        chk("throughput_cycles", 64'(cyc - c0), 64'(NV));
        drain();

        // Stall with input pressure: capacity fills, then in_ready drops.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx = 0;
        acc = 0;
        in_instr = vi[idx];
        in_tag   = 5'(20 + idx);
        repeat (5) begin
            @(negedge clk);
            got = in_ready;
            if (got) begin
                sb.push_back('{imm: vimm[idx], fmt: vfmt[idx], tag: 5'(20 + idx)});
                acc++;
            end
            @(posedge clk);
            #1;
            if (got) begin
                idx++;
                in_instr = vi[idx];
                in_tag   = 5'(20 + idx);
            end
        end
        in_valid = 1'b0;
        chk("stall_accepts", 64'(acc), 64'(CAP));
        @(negedge clk);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Flush with full storage and a pending input.
        out_ready = 1'b0;
        for (int k = 0; k < CAP; k++) send(k + 2, 5'(10 + k));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = vi[4];
        in_tag   = 5'd31;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Flush while an input actually transfers: it must vanish.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = vi[3];
        in_tag   = 5'd30;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_xfer_out_valid", 64'(out_valid), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        // Mixed traffic with a fixed out_ready pattern.
        toggle_en = 1'b1;
        for (int n = 0; n < 48; n++) send(n % NV, 5'(n));
        toggle_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of held traffic.
        out_ready = 1'b0;
        for (int k = 0; k < CAP; k++) send(k + 6, 5'(k + 3));
        reset    = 1'b1;
        in_valid = 1'b1;
        in_instr = vi[1];
        in_tag   = 5'd29;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_imm", out_imm, 64'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_release_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_release_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 64, datapath width of the immediate; legal values are 32 and 64.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried alongside each instruction.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discards all held entries; synchronous.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 in_instr  input  32  instruction word.
REQ-009 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_imm  output  XLEN  sign-extended immediate.
REQ-013 out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-014 out_tag  output  TAG_W  tag of the result.
REQ-015 out_illegal  output  1  opcode unrecognised; equals (out_fmt==ILL).

Function
REQ-016 A transfer occurs on each side when valid&ready are both high in the same cycle; results SHALL leave in strict arrival order.
REQ-017 Latency SHALL be 1 cycle: an accepted instruction is presented on out_* the next cycle at the earliest.
REQ-018 Decode on in_instr[6:0]: 0000011, 0010011, 0011011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011, 0111011 -> R; all others -> ILL.
REQ-019 Immediates: I {i[31:20]}; S {i[31:25],i[11:7]}; B {i[31],i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {i[31],i[19:12],i[20],i[30:21],0}; each sign-extended from bit 31 of the instruction to XLEN.
REQ-020 For R and ILL, out_imm SHALL be 0.
REQ-021 While out_valid=1 and out_ready=0, out_imm, out_fmt, out_tag and out_illegal SHALL hold stable.
REQ-022 flush=1 SHALL invalidate every held entry by the next edge; an input transferred in the same cycle as flush SHALL be dropped.
REQ-023 flush and reset SHALL take priority over any simultaneous transfer.
REQ-024 Full condition: with all entries occupied and out_ready=0, in_ready SHALL be 0 and no entry is overwritten.
REQ-025 Simultaneous pop and push on a full stage SHALL be accepted without a bubble.

Reset
REQ-026 During reset and on the first cycle after it: out_valid=0, out_imm=0, out_fmt=0, out_tag=0, out_illegal=0; all entries empty.
REQ-027 in_ready SHALL be 0 while reset=1 and 1 on the first cycle after reset deasserts.
REQ-028 Reset asserted mid-transfer SHALL discard all entries, with no partial result emitted.

Configuration
REQ-029 Macro IMM_GEN_SKID_EN defined: 2-entry skid buffer; in_ready SHALL be a registered signal equal to "skid entry empty", with no combinational path from out_ready.
REQ-030 Macro IMM_GEN_SKID_EN undefined: single output register; in_ready = out_ready | ~out_valid (combinational). Sustained throughput is 1 per cycle in both builds.

Structure
REQ-031 A shared package imm_gen_pkg SHALL hold the format code constants, the opcode constants and the XLEN legal-value check.
REQ-032 Combinational decode SHALL live in a sub-module imm_gen_decode (instr -> imm, fmt); imm_gen_pipe SHALL contain only the storage and handshake.

Verification
REQ-033 addi 0xFFF00093 with XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=1, after 1 cycle.
REQ-034 sw 0xFE112E23 -> out_imm=-4 (0xFFFFFFFFFFFFFFFC), out_fmt=2; lui 0x800002B7 -> 0xFFFFFFFF80000000, out_fmt=4; jal 0x001000EF -> 0x800, out_fmt=5.
REQ-035 in_instr=0x0000007F -> out_illegal=1, out_fmt=7, out_imm=0.
REQ-036 Set out_ready=0 for 5 cycles with in_valid=1 -> outputs stable. With IMM_GEN_SKID_EN, in_ready falls after 2 accepts, otherwise after 1. Then set out_ready=1 -> tags emerge in order, no loss and no duplicates.
REQ-037 Assert flush with 2 entries held and in_valid=1 -> out_valid=0 next cycle and the flushed input never appears.
REQ-038 Random traffic with out_ready toggling, 10k instructions, in both macro builds -> scoreboard matches the reference decode in order.
